// File: rtl/line_window_buf.sv
// 3x3 neighbourhood generator: two circular line buffers plus a column shift
// register, emitting interior windows with centre coordinates through one output stage.
//
// state  | meaning
// IDLE   | no frame in progress; non-sof pixels are discarded
// ACTIVE | frame in progress; pixels advance (row, col)
module line_window_buf #(
    parameter int MAX_WIDTH = 1024,
    parameter int PIX_W     = 8,
    parameter int COL_W     = $clog2(MAX_WIDTH + 1),
    parameter int ROW_W     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [COL_W-1:0]       img_width,
    input  logic                   sof,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIX_W-1:0]       pixel_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8:0][PIX_W-1:0]  window_out,
    output logic [ROW_W-1:0]       out_row,
    output logic [COL_W-1:0]       out_col,
    output logic                   out_eol,
    output logic                   cfg_err
);
    localparam int AW = $clog2(MAX_WIDTH);
    localparam logic [COL_W-1:0] MAX_W   = COL_W'(MAX_WIDTH);
    localparam logic [COL_W-1:0] MIN_W   = COL_W'(3);
    localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);
    localparam logic [ROW_W-1:0] ROW_MAX = '1;

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;

    logic [COL_W-1:0] width, col;
    logic [ROW_W-1:0] row;
    logic             width_ok;

    logic [PIX_W-1:0] lb0 [MAX_WIDTH];
    logic [PIX_W-1:0] lb1 [MAX_WIDTH];

    // [1] holds column c-1, [0] holds column c-2
    logic [1:0][PIX_W-1:0] top_sr, mid_sr, bot_sr;

    logic             accept, process, load;
    logic             new_ok, new_err, cur_ok;
    logic [COL_W-1:0] new_width, cur_width, cur_col, last_col;
    logic [ROW_W-1:0] cur_row;
    logic [AW-1:0]    addr;
    logic [PIX_W-1:0] up1, up2;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign process  = accept && (sof || state == ACTIVE);

    always_comb begin
        new_width = img_width;
        new_ok    = 1'b1;
        new_err   = 1'b0;
        if (img_width > MAX_W) begin
            new_width = MAX_W;
            new_err   = 1'b1;
        end else if (img_width < MIN_W) begin
            new_ok  = 1'b0;
            new_err = 1'b1;
        end
    end

    // An accepted sof pixel is always (0,0) under the freshly latched width.
    assign cur_width = sof ? new_width : width;
    assign cur_ok    = sof ? new_ok : width_ok;
    assign cur_col   = sof ? '0 : col;
    assign cur_row   = sof ? '0 : row;
    assign last_col  = cur_width - COL_ONE;
    assign addr      = cur_col[AW-1:0];
    assign up1       = lb1[addr];
    assign up2       = lb0[addr];
    assign load      = process && cur_ok && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

    // Line buffers are not reset; windows are gated until two full rows exist.
    always_ff @(posedge clock) begin
        if (process && cur_ok) begin
            lb1[addr] <= pixel_in;
            lb0[addr] <= up1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            width      <= '0;
            width_ok   <= 1'b0;
            col        <= '0;
            row        <= '0;
            cfg_err    <= 1'b0;
            top_sr     <= '0;
            mid_sr     <= '0;
            bot_sr     <= '0;
            out_valid  <= 1'b0;
            window_out <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_eol    <= 1'b0;
        end else begin
            if (accept && sof) begin
                state    <= ACTIVE;
                width    <= new_width;
                width_ok <= new_ok;
                if (new_err)
                    cfg_err <= 1'b1;
            end

            if (process) begin
                if (!cur_ok) begin
                    col <= '0;
                    row <= '0;
                end else if (cur_col == last_col) begin
                    col <= '0;
                    row <= (cur_row == ROW_MAX) ? cur_row : cur_row + ROW_ONE;
                end else begin
                    col <= cur_col + COL_ONE;
                    row <= cur_row;
                end
                top_sr <= {up2, top_sr[1]};
                mid_sr <= {up1, mid_sr[1]};
                bot_sr <= {pixel_in, bot_sr[1]};
            end

            if (load) begin
                out_valid     <= 1'b1;
                window_out[0] <= top_sr[0];
                window_out[1] <= top_sr[1];
                window_out[2] <= up2;
                window_out[3] <= mid_sr[0];
                window_out[4] <= mid_sr[1];
                window_out[5] <= up1;
                window_out[6] <= bot_sr[0];
                window_out[7] <= bot_sr[1];
                window_out[8] <= pixel_in;
                out_row       <= cur_row - ROW_ONE;
                out_col       <= cur_col - COL_ONE;
                out_eol       <= (cur_col == last_col);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_line_window_buf.sv
// Directed bench for line_window_buf: frames of known pixel values, window
// sequences checked against a reference built from the pixel formula.
module tb_line_window_buf;
    localparam int MAXW = 16;
    localparam int PW   = 8;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int RW   = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic [CW-1:0]       img_width;
    logic                sof, in_valid, in_ready;
    logic [PW-1:0]       pixel_in;
    logic                out_valid, out_ready;
    logic [8:0][PW-1:0]  window_out;
    logic [RW-1:0]       out_row;
    logic [CW-1:0]       out_col;
    logic                out_eol, cfg_err;

    line_window_buf #(.MAX_WIDTH(MAXW), .PIX_W(PW), .COL_W(CW), .ROW_W(RW)) dut (
        .clock(clock), .reset(reset), .img_width(img_width), .sof(sof),
        .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
        .out_valid(out_valid), .out_ready(out_ready), .window_out(window_out),
        .out_row(out_row), .out_col(out_col), .out_eol(out_eol), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [8:0][PW-1:0] win;
        logic [RW-1:0]      row;
        logic [CW-1:0]      col;
        logic               eol;
    } rec_t;

    rec_t got[$];
    rec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mode  = 0;
    logic stalled = 1'b0;
    rec_t held, cur;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // out_ready: constantly high in mode 0, toggles every 3 cycles in mode 1
    initial begin
        int k = 0;
        out_ready = 1'b1;
        forever begin
            @(negedge clock);
            k++;
            if (mode == 0)
                out_ready = 1'b1;
            else if (k % 3 == 0)
                out_ready = !out_ready;
        end
    end

    // Collect transferred windows; check stability and backpressure while stalled.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            cur = '{win: window_out, row: out_row, col: out_col, eol: out_eol};
            if (stalled)
                check("hold_stable", cur, held);
            if (out_valid && out_ready)
                got.push_back(cur);
            stalled = out_valid && !out_ready;
            if (stalled) begin
                held = cur;
                check("stall_in_ready", in_ready, 1'b0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_pix(input logic s, input int p, input int w);
        logic rdy;
        int   tries;
        sof       = s;
        pixel_in  = PW'(p);
        img_width = CW'(w);
        in_valid  = 1'b1;
        rdy       = 1'b0;
        tries     = 0;
        while (!rdy && tries < 50) begin
            @(negedge clock);
            #2;
            rdy = in_ready;
            @(posedge clock);
            #1;
            tries++;
        end
        if (!rdy)
            check("accept_timeout", rdy, 1'b1);
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    // Sends an h-row frame of w_real columns; pixel = base + 10r + c.
    task automatic send_frame(input int w_cfg, input int w_real, input int h, input int base,
                              input logic lat_chk);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w_real; c++) begin
                send_pix(r == 0 && c == 0, base + 10 * r + c, w_cfg);
                if (lat_chk)
                    check($sformatf("latency_r%0d_c%0d", r, c), out_valid,
                          (r >= 2 && c >= 2 && w_real >= 3));
            end
    endtask

    task automatic add_exp(input int w, input int h, input int base);
        rec_t e;
        for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++) begin
                for (int dy = 0; dy < 3; dy++)
                    for (int dx = 0; dx < 3; dx++)
                        e.win[3 * dy + dx] = PW'(base + 10 * (r - 2 + dy) + (c - 2 + dx));
                e.row = RW'(r - 1);
                e.col = CW'(c - 1);
                e.eol = (c == w - 1);
                exp_q.push_back(e);
            end
    endtask

    task automatic check_q(input string tag);
        int n;
        check({tag, "_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_win%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        sof       = 1'b0;
        pixel_in  = '0;
        img_width = '0;
        idle(3);
        reset = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_window", window_out, '0);
        check("rst_row", out_row, '0);
        check("rst_col", out_col, '0);
        check("rst_eol", out_eol, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // 5x4 frame, downstream always ready
        got.delete();
        send_frame(5, 5, 4, 0, 1'b1);
        idle(5);
        check("s1_drained", out_valid, 1'b0);
        add_exp(5, 4, 0);
        check_q("s1");

        // same frame with periodic backpressure
        mode = 1;
        send_frame(5, 5, 4, 0, 1'b0);
        idle(4);
        mode = 0;
        idle(6);
        add_exp(5, 4, 0);
        check_q("s2");

        // leading non-sof pixels after reset are discarded
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        got.delete();
        for (int i = 0; i < 7; i++)
            send_pix(1'b0, 50 + i, 5);
        check("s3_idle_no_out", out_valid, 1'b0);
        send_frame(5, 5, 4, 0, 1'b1);
        idle(5);
        add_exp(5, 4, 0);
        check_q("s3");

        // aborted partial frame, then W=5 and W=8 frames back to back
        send_frame(5, 5, 2, 200, 1'b0);
        send_pix(1'b0, 220, 5);
        send_pix(1'b0, 221, 5);
        send_frame(5, 5, 3, 0, 1'b1);
        send_frame(8, 8, 3, 100, 1'b1);
        idle(5);
        add_exp(5, 3, 0);
        add_exp(8, 3, 100);
        check_q("s4");

        // bad widths: too narrow, then clamped to MAXW
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        got.delete();
        send_pix(1'b1, 0, 2);
        check("s5_cfg_err_rise", cfg_err, 1'b1);
        send_frame(2, 2, 3, 0, 1'b1);
        idle(3);
        check_q("s5_narrow");
        send_frame(MAXW + 5, MAXW, 3, 0, 1'b1);
        idle(5);
        check("s5_cfg_err_sticky", cfg_err, 1'b1);
        add_exp(MAXW, 3, 0);
        check_q("s5_clamped");

        // reset mid-frame while a window is pending
        send_frame(5, 5, 2, 0, 1'b0);
        send_pix(1'b0, 20, 5);
        send_pix(1'b0, 21, 5);
        send_pix(1'b0, 22, 5);
        check("s6_pre_valid", out_valid, 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        got.delete();
        check("s6_out_valid", out_valid, 1'b0);
        check("s6_window", window_out, '0);
        check("s6_row", out_row, '0);
        check("s6_col", out_col, '0);
        check("s6_eol", out_eol, 1'b0);
        check("s6_cfg_err", cfg_err, 1'b0);
        send_pix(1'b0, 23, 5);
        send_pix(1'b0, 24, 5);
        for (int c = 0; c < 5; c++)
            send_pix(1'b0, 30 + c, 5);
        idle(3);
        check_q("s6_discard");
        send_frame(5, 5, 3, 0, 1'b1);
        idle(5);
        add_exp(5, 3, 0);
        check_q("s6_new_frame");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
